// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Two-port Avalon-MM arbiter in front of a single SDRAM controller.
// A three-state FSM (IDLE / BUSY0 / BUSY1) passes one requester's command
// through at a time. A 4-entry read-tag FIFO remembers which requester
// issued each outstanding read so returning data is steered back in order.
// Read data reaches the requesters with no added latency.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration of simultaneous requests. Without it M0 has fixed priority.
module sdram_port_arbiter (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [23:0] m0_address,
    input  logic [15:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [15:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [23:0] m1_address,
    input  logic [15:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [15:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        s_read,
    output logic        s_write,
    output logic [23:0] s_address,
    output logic [15:0] s_writedata,
    input  logic        s_waitrequest,
    input  logic [15:0] s_readdata,
    input  logic        s_readdatavalid,
    output logic        err_orphan
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  tag_q, tag_d;          // one requester-ID bit per FIFO slot
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        err_orphan_q, err_orphan_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic        rr_q, rr_d;            // 1: M1 preferred on the next tie
`endif

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        elig0_s;
    logic        elig1_s;
    logic        grant_any_s;
    logic        grant1_s;
    logic        busy0_s;
    logic        busy1_s;
    logic        push_s;
    logic        pop_s;
    logic        head_id_s;

    // Eligibility and arbitration between the two requesters
    always_comb begin
        fifo_full_s  = (count_q == 3'd4);
        fifo_empty_s = (count_q == 3'd0);
        elig0_s      = m0_write | (m0_read & ~fifo_full_s);
        elig1_s      = m1_write | (m1_read & ~fifo_full_s);
        grant_any_s  = elig0_s | elig1_s;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        if (elig0_s && elig1_s) begin
            grant1_s = rr_q;
        end else begin
            grant1_s = elig1_s;
        end
`else
        grant1_s = elig1_s & ~elig0_s;
`endif
    end

    // Next-state logic of the arbitration FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    state_d = grant1_s ? ST_BUSY1 : ST_BUSY0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY0: begin
                if (!m0_read && !m0_write) begin
                    state_d = ST_IDLE;          // requester withdrew
                end else if (!s_waitrequest) begin
                    state_d = ST_IDLE;          // command accepted
                end else begin
                    state_d = ST_BUSY0;
                end
            end
            ST_BUSY1: begin
                if (!m1_read && !m1_write) begin
                    state_d = ST_IDLE;
                end else if (!s_waitrequest) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: command mux toward the controller and waitrequest steering
    always_comb begin
        // Reset held high suppresses any command, even mid-transaction
        busy0_s        = (state_q == ST_BUSY0) & ~reset_reset;
        busy1_s        = (state_q == ST_BUSY1) & ~reset_reset;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = 24'h000000;
        s_writedata    = 16'h0000;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (busy0_s) begin
            s_read         = m0_read;
            s_write        = m0_write;
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            m0_waitrequest = s_waitrequest;
        end else if (busy1_s) begin
            s_read         = m1_read;
            s_write        = m1_write;
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            m1_waitrequest = s_waitrequest;
        end else begin
            s_read         = 1'b0;
            s_write        = 1'b0;
        end
    end

    // Read-tag FIFO, orphan detection and read-data steering
    always_comb begin
        // Full guard is defensive: a read is only granted when a slot is free
        push_s    = s_read & ~s_waitrequest & ~fifo_full_s;
        pop_s     = s_readdatavalid & ~fifo_empty_s;
        head_id_s = tag_q[rd_ptr_q];

        tag_d = tag_q;
        if (push_s) begin
            tag_d[wr_ptr_q] = busy1_s;
        end else begin
            tag_d = tag_q;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push_s};
        rd_ptr_d = rd_ptr_q + {1'b0, pop_s};
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        err_orphan_d = err_orphan_q | (s_readdatavalid & fifo_empty_s);
        err_orphan   = err_orphan_q;

        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = pop_s & ~head_id_s;
        m1_readdatavalid = pop_s & head_id_s;
    end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: after each grant prefer the other requester
    always_comb begin
        if ((state_q == ST_IDLE) && grant_any_s) begin
            rr_d = ~grant1_s;
        end else begin
            rr_d = rr_q;
        end
    end
`endif

    // State register: FSM, FIFO and sticky error with synchronous reset
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            tag_q        <= 4'h0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            err_orphan_q <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`endif
        end
    end

endmodule
